// File: rtl/rx_chan_fifo.sv
// rx_chan_fifo: single-clock multichannel receive FIFO.
// On each strobe, one sample from each active channel is captured into a
// shadow register. The serializer then writes the samples ch0-first into a
// RAM FIFO, one word per clock. A sample set is either accepted whole or
// dropped whole, and a dropped set raises the sticky overflow flag. The
// reader drains the FIFO one word per rd_req, with one cycle of latency.
//
// Ports:
//   clk          - clock; all logic runs on its rising edge
//   reset_n      - asynchronous active-low reset
//   clear        - synchronous flush; empties the FIFO and aborts the serializer
//   clear_status - synchronous clear of the sticky overflow flag
//   strobe       - one-cycle pulse; a sample set is valid on din
//   channels     - active channel count (clamped to MAX_CH), sampled on strobe
//   din          - channel k is at din[k*DATA_W +: DATA_W]
//   rd_req       - read request, one word per cycle
//   dout         - registered read data
//   packet_rdy   - fill >= PKT_WORDS
//   overflow     - sticky; set when a sample set was dropped
//   fill         - number of words currently stored
module rx_chan_fifo #(
  parameter int DATA_W    = 16,
  parameter int MAX_CH    = 8,
  parameter int ADDR_W    = 10,
  parameter int PKT_WORDS = 256
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     clear_status,
  input  logic                     strobe,
  input  logic [3:0]               channels,
  input  logic [MAX_CH*DATA_W-1:0] din,
  input  logic                     rd_req,
  output logic [DATA_W-1:0]        dout,
  output logic                     packet_rdy,
  output logic                     overflow,
  output logic [ADDR_W:0]          fill
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned MAXC_U = MAX_CH;
  localparam int          IDX_W  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t             state;
  logic [DATA_W-1:0]  mem    [DEPTH];
  logic [DATA_W-1:0]  shadow [MAX_CH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]   ch_idx;
  logic [IDX_W-1:0]   last_idx;
  logic [ADDR_W:0]    fill_r;

  int unsigned        nch;
  int unsigned        space;
  logic               accept;
  logic               drop;
  logic               wr_en;
  logic               rd_en;

  // The space check covers the whole set at strobe time, so a set that
  // passes can never hit a full FIFO while it is being serialized.
  always_comb begin
    nch = 32'(channels);
    if (nch > MAXC_U) nch = MAXC_U;
    space  = DEPTH - 32'(fill_r);
    accept = 1'b0;
    drop   = 1'b0;
    if (strobe && !clear && nch != 0) begin
      if (state == IDLE && space >= nch) accept = 1'b1;
      else                               drop   = 1'b1;
    end
    wr_en = (state == WRITE) && !clear;
    rd_en = rd_req && (fill_r != '0) && !clear;
  end

  assign fill       = fill_r;
  assign packet_rdy = (fill_r >= (ADDR_W+1)'(PKT_WORDS));

  // Storage: the RAM and shadow register carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k < MAXC_U; k++)
        shadow[k] <= din[k*DATA_W +: DATA_W];
    end
    if (wr_en) mem[wr_ptr] <= shadow[ch_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ch_idx   <= '0;
      last_idx <= '0;
      fill_r   <= '0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      // A drop takes priority over a clear in the same cycle.
      if (drop)              overflow <= 1'b1;
      else if (clear_status) overflow <= 1'b0;

      if (clear) begin
        state  <= IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        ch_idx <= '0;
        fill_r <= '0;
      end else begin
        if (rd_en) begin
          dout   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;

        if (wr_en && !rd_en)      fill_r <= fill_r + 1'b1;
        else if (rd_en && !wr_en) fill_r <= fill_r - 1'b1;

        case (state)
          IDLE: begin
            if (accept) begin
              ch_idx   <= '0;
              last_idx <= IDX_W'(nch - 1);
              state    <= WRITE;
            end
          end
          WRITE: begin
            if (ch_idx == last_idx) begin
              ch_idx <= '0;
              state  <= IDLE;
            end else begin
              ch_idx <= ch_idx + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_chan_fifo.sv
module tb_rx_chan_fifo;
  localparam int DW    = 16;
  localparam int MCH   = 8;
  localparam int AW    = 4;
  localparam int PKT   = 8;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clear, clear_status, strobe, rd_req;
  logic [3:0]        channels;
  logic [MCH*DW-1:0] din;
  logic [DW-1:0]     dout;
  logic              packet_rdy, overflow;
  logic [AW:0]       fill;

  rx_chan_fifo #(.DATA_W(DW), .MAX_CH(MCH), .ADDR_W(AW), .PKT_WORDS(PKT)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .clear_status(clear_status),
    .strobe(strobe), .channels(channels), .din(din), .rd_req(rd_req),
    .dout(dout), .packet_rdy(packet_rdy), .overflow(overflow), .fill(fill)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: m_q holds words stored in the FIFO (scoreboard),
  // m_pend holds words of an accepted set not yet written.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_pend[$];
  logic          m_ovf  = 1'b0;
  logic [DW-1:0] m_dout = '0;

  typedef struct {
    logic        strb;
    logic [3:0]  ch;
    logic        rd;
    logic        clr;
    logic        clrs;
    logic [15:0] base;
    int          exp_fill;
    logic        exp_ovf;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [MCH*DW-1:0] mk_din(input logic [15:0] base);
    logic [MCH*DW-1:0] d;
    for (int k = 0; k < MCH; k++) d[k*DW +: DW] = base + 16'(k * 16'h1111);
    return d;
  endfunction

  task automatic model_step(input logic s, input logic [3:0] ch, input logic rd,
                            input logic clr, input logic clrs, input logic [15:0] base);
    int  nch;
    int  fill_pre;
    bit  busy;
    bit  drp;
    fill_pre = m_q.size();
    busy     = (m_pend.size() != 0);
    nch      = (ch > 8) ? 8 : int'(ch);
    drp      = 0;
    if (clr) begin
      m_q.delete();
      m_pend.delete();
    end else begin
      if (rd && m_q.size() > 0) m_dout = m_q.pop_front();
      if (busy) m_q.push_back(m_pend.pop_front());
      if (s && nch > 0) begin
        if (busy || (DEPTH - fill_pre) < nch) drp = 1;
        else for (int k = 0; k < nch; k++) m_pend.push_back(base + 16'(k * 16'h1111));
      end
    end
    if (drp) m_ovf = 1'b1;
    else if (clrs) m_ovf = 1'b0;
  endtask

  task automatic tick(input logic s, input logic [3:0] ch, input logic rd,
                      input logic clr, input logic clrs, input logic [15:0] base);
    strobe = s; channels = ch; rd_req = rd; clear = clr; clear_status = clrs;
    din = mk_din(base);
    @(posedge clk);
    model_step(s, ch, rd, clr, clrs, base);
    #1;
    chk("fill", int'(fill), m_q.size());
    chk("packet_rdy", int'(packet_rdy), int'(m_q.size() >= PKT));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("dout", int'(dout), int'(m_dout));
    strobe = 0; rd_req = 0; clear = 0; clear_status = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 4'd0, 0, 0, 0, 16'h0);
  endtask

  task automatic add(input logic s, input logic [3:0] ch, input logic rd, input logic clr,
                     input logic clrs, input logic [15:0] base, input int ef, input logic eo);
    vec_t v;
    v.strb = s; v.ch = ch; v.rd = rd; v.clr = clr; v.clrs = clrs;
    v.base = base; v.exp_fill = ef; v.exp_ovf = eo;
    vt.push_back(v);
  endtask

  task automatic do_reset_check(input string nm);
    reset_n = 1'b0;
    #1;
    chk({nm, "_fill"}, int'(fill), 0);
    chk({nm, "_pkt"}, int'(packet_rdy), 0);
    chk({nm, "_ovf"}, int'(overflow), 0);
    chk({nm, "_dout"}, int'(dout), 0);
    m_q.delete(); m_pend.delete(); m_ovf = 1'b0; m_dout = '0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; strobe = 0; channels = 0; rd_req = 0; clear = 0;
    clear_status = 0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset_check("reset");

    // Basic set of 4, readback, read on empty
    add(1, 4'd4, 0, 0, 0, 16'h1111, 0, 0);
    add(0, 4'd0, 0, 0, 0, 16'h0, 1, 0);
    add(0, 4'd0, 0, 0, 0, 16'h0, 2, 0);
    add(0, 4'd0, 0, 0, 0, 16'h0, 3, 0);
    add(0, 4'd0, 0, 0, 0, 16'h0, 4, 0);
    add(0, 4'd0, 1, 0, 0, 16'h0, 3, 0);
    add(0, 4'd0, 1, 0, 0, 16'h0, 2, 0);
    add(0, 4'd0, 1, 0, 0, 16'h0, 1, 0);
    add(0, 4'd0, 1, 0, 0, 16'h0, 0, 0);
    add(0, 4'd0, 1, 0, 0, 16'h0, 0, 0);
    // nch=8, second strobe 3 clks later is dropped
    add(1, 4'd8, 0, 0, 0, 16'h0100, 0, 0);
    add(0, 4'd0, 0, 0, 0, 16'h0, 1, 0);
    add(0, 4'd0, 0, 0, 0, 16'h0, 2, 0);
    add(1, 4'd8, 0, 0, 0, 16'h0A00, 3, 1);
    for (int i = 4; i <= 8; i++) add(0, 4'd0, 0, 0, 0, 16'h0, i, 1);
    add(0, 4'd0, 0, 0, 1, 16'h0, 8, 0);
    add(0, 4'd0, 0, 1, 0, 16'h0, 0, 0);
    // channels=0 ignored, channels=9 clamps to 8
    add(1, 4'd0, 0, 0, 0, 16'h0, 0, 0);
    add(0, 4'd0, 0, 0, 0, 16'h0, 0, 0);
    add(1, 4'd9, 0, 0, 0, 16'h0900, 0, 0);
    for (int i = 1; i <= 8; i++) add(0, 4'd0, 0, 0, 0, 16'h0, i, 0);
    // strobe alongside clear is ignored
    add(1, 4'd2, 0, 1, 0, 16'h0C00, 0, 0);
    add(0, 4'd0, 0, 0, 0, 16'h0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      tick(vt[i].strb, vt[i].ch, vt[i].rd, vt[i].clr, vt[i].clrs, vt[i].base);
      chk($sformatf("vec%0d_fill", i), int'(fill), vt[i].exp_fill);
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vt[i].exp_ovf));
    end

    // Fill a depth-16 FIFO with sets of 3; the 6th set is dropped whole
    for (int s = 0; s < 6; s++) begin
      tick(1, 4'd3, 0, 0, 0, 16'h3000 + 16'(s * 16'h100));
      idle(3);
    end
    chk("full_fill", int'(fill), 15);
    chk("full_ovf", int'(overflow), 1);
    tick(0, 4'd0, 0, 0, 1, 16'h0);
    chk("clrs_ovf", int'(overflow), 0);
    tick(1, 4'd2, 0, 0, 1, 16'h7000);
    chk("set_wins_ovf", int'(overflow), 1);
    chk("set_wins_fill", int'(fill), 15);
    tick(0, 4'd0, 0, 0, 1, 16'h0);
    for (int i = 0; i < 16; i++) tick(0, 4'd0, 1, 0, 0, 16'h0);
    chk("drain_fill", int'(fill), 0);

    // Concurrent random traffic with pointer wrap
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 3) == 0, 4'($urandom_range(0, 9)), ($urandom % 2) == 0,
           0, ($urandom % 16) == 0, 16'($urandom));
      if (fill > 16) chk("fill_bound", int'(fill), 16);
    end
    for (int i = 0; i < 24; i++) tick(0, 4'd0, 1, 0, 0, 16'h0);

    // Reset mid-serialization, then a fresh set
    tick(0, 4'd0, 0, 1, 0, 16'h0);
    tick(1, 4'd4, 0, 0, 0, 16'h5000);
    idle(2);
    chk("pre_reset_fill", int'(fill), 2);
    do_reset_check("midreset");
    tick(1, 4'd4, 0, 0, 0, 16'h6000);
    idle(4);
    chk("post_reset_fill", int'(fill), 4);
    tick(0, 4'd0, 1, 0, 0, 16'h0);
    chk("post_reset_w0", int'(dout), 16'h6000);
    tick(0, 4'd0, 1, 0, 0, 16'h0);
    chk("post_reset_w1", int'(dout), 16'h7111);
    tick(0, 4'd0, 1, 0, 0, 16'h0);
    tick(0, 4'd0, 1, 0, 0, 16'h0);
    chk("post_reset_w3", int'(dout), 16'h9333);
    chk("post_reset_empty", int'(fill), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
